instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction-fetch unit of the multicycle CPU. It sits directly downstream of `program_counter`. On the `PH_F` phase it captures the current PC and runs a request/acknowledge read on the instruction-memory port, then latches the returned word into the instruction register. While the read is outstanding it stalls the phase sequencer. Misaligned PCs and unanswered requests are reported as sticky faults.

## Interface
Parameters:
- `TIMEOUT`, default 255: maximum cycles in REQ without `imem_ack` before a timeout fault. 0 disables the timeout.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `n_rst`  in  1  reset, asynchronous, active-low.
- `hlt`  in  1  synchronous clear to reset state, same role as in `program_counter`.
- `phase`  in  5  one-hot phase from the sequencer (`PH_F`, `PH_D`, `PH_E`, `PH_M`, `PH_W` in header.v).
- `pc`  in  32  current PC from `program_counter`; valid in the `PH_F` cycle.
- `imem_req`  out  1  read request to instruction memory; held until ack.
- `imem_addr`  out  32  read address; stable while `imem_req`=1.
- `imem_rdata`  in  32  read data; valid when `imem_ack`=1.
- `imem_ack`  in  1  one-cycle acknowledge.
- `ir`  out  32  instruction register.
- `ir_valid`  out  1  one-cycle pulse when `ir` has just been loaded.
- `fetch_busy`  out  1  stall; the sequencer holds `PH_D` while it is 1.
- `fetch_fault`  out  1  sticky fault flag.
- `fault_cause`  out  2  fault code: 00 none, 01 misaligned, 10 timeout.

## Operation
- States: IDLE, REQ, FAULT.
- Reset (`n_rst`=0): state IDLE. Every output is 0: `imem_req`, `imem_addr`, `ir`, `ir_valid`, `fetch_busy`, `fetch_fault`, `fault_cause`. The timeout counter is also 0.
- `hlt`=1 at a clock edge: same values as reset, regardless of state. An outstanding request is abandoned. Any ack that arrives later is ignored because the unit is in IDLE.
- In IDLE with `phase`==`PH_F`:
  - If `pc[1:0]`==0: `imem_addr`<=`pc`, `imem_req`<=1, counter<=0, go to REQ.
  - If `pc[1:0]`!=0: go to FAULT with `fault_cause`=01. No request is issued.
- In REQ with `imem_ack`=1: `ir`<=`imem_rdata`, `ir_valid`<=1 for one cycle, `imem_req`<=0, go to IDLE.
- In REQ without ack: the counter increments. If the counter reaches `TIMEOUT` (and `TIMEOUT`!=0): `imem_req`<=0, go to FAULT with `fault_cause`=10.
- Ack and timeout expiry in the same cycle: the ack wins and the fetch completes normally.
- `imem_ack` while in IDLE or FAULT: ignored; `ir` is unchanged.
- `phase`==`PH_F` while in REQ or FAULT: ignored. This cannot occur with a correct sequencer, because `fetch_busy` prevents it.
- FAULT: `fetch_fault`=1 and `fault_cause` are held, `fetch_busy`=0. The state is left only by `hlt` or reset.
- `fetch_busy` = (state==REQ), decoded from registered state.
- Counter width is `$clog2(TIMEOUT+1)`, minimum 1. The counter saturates and does not wrap.

## Timing
- Cycle 0 (`PH_F`): the PC is sampled. `program_counter` updates `pc` to `pc`+4 on this same edge, so only the cycle-0 value is used.
- Cycle 1 (`PH_D`): `imem_req`=1 and `fetch_busy`=1.
- `imem_ack` arrives no earlier than cycle 1. For an ack in cycle k:
  - in cycle k+1: `ir` holds the new word, `ir_valid`=1, `fetch_busy`=0, `imem_req`=0;
  - minimum fetch latency is 2 cycles from `PH_F` to valid `ir`.
- Timeout: REQ starts in cycle 1, so `imem_req` drops and `fetch_fault` rises in cycle `TIMEOUT`+2.
- Misaligned PC: `fetch_fault` rises in cycle 1 and `fetch_busy` stays 0.
- Asynchronous reset mid-REQ: `imem_req` deasserts immediately, with no clock required.

## Structure
- header.v: add the state codes `IF_IDLE`, `IF_REQ`, `IF_FAULT` and the fault codes `IF_FLT_NONE`, `IF_FLT_ALIGN`, `IF_FLT_TMO`, alongside the existing `PH_*` macros.
- One sub-module, `fetch_timer`: a saturating counter with clear/enable/expire. It is instantiated once and is reusable for data-memory timeouts.

## Test plan
- Aligned fetch: `pc`=0x100 in `PH_F`, ack in cycle 3 with rdata 0xDEADBEEF. Required: `imem_addr`=0x100 in cycles 1–3, `fetch_busy` 1 in cycles 1–3, `ir`=0xDEADBEEF and `ir_valid`=1 in cycle 4.
- Fastest ack: ack in cycle 1. Required: `ir` loaded in cycle 2, and `imem_req` high for exactly 1 cycle.
- Misaligned PC: `pc`=0x102 in `PH_F`. Required: `imem_req` never 1; `fetch_fault`=1 and `fault_cause`=01 from cycle 1 until `hlt`.
- Timeout with `TIMEOUT`=4 and no ack. Required: `imem_req` drops and `fault_cause`=10 in cycle 6. Repeat with ack arriving in the expiry cycle: the fetch completes normally and no fault is raised.
- `hlt` in cycle 2 of an outstanding fetch, then an ack in cycle 4. Required: all outputs 0 from cycle 3, and `ir` stays 0.
- `n_rst` asserted mid-REQ. Required: `imem_req`=0 immediately. After release, a new `PH_F` fetch works normally.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | instr_fetch_pkg: phase codes, fetch FSM states, fault codes and helpers.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package instr_fetch_pkg;

  localparam logic [4:0] PH_F = 5'b00001;
  localparam logic [4:0] PH_D = 5'b00010;
  localparam logic [4:0] PH_E = 5'b00100;
  localparam logic [4:0] PH_M = 5'b01000;
  localparam logic [4:0] PH_W = 5'b10000;

  typedef enum logic [1:0] {
    IF_IDLE  = 2'b00,
    IF_REQ   = 2'b01,
    IF_FAULT = 2'b10
  } if_state_e;

  localparam logic [1:0] IF_FLT_NONE  = 2'b00;
  localparam logic [1:0] IF_FLT_ALIGN = 2'b01;
  localparam logic [1:0] IF_FLT_TMO   = 2'b10;

  function automatic logic word_aligned(input logic [1:0] addr_lsbs);
    return addr_lsbs == 2'b00;
  endfunction

  function automatic int timer_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/instr_fetch_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fetch_timer: saturating cycle counter with clear, enable and expire flag.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module fetch_timer
  import instr_fetch_pkg::*;
#(
  parameter int LIMIT = 255,
  parameter int W     = timer_width(LIMIT)
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // A limit of zero means the timer never expires.
  assign expired = (LIMIT != 0) && (count_q == W'(LIMIT));

endmodule
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | instr_fetch: PH_F-triggered req/ack instruction read into the IR, with     |
// | sticky misalignment and timeout faults.  Rev 1.0                           |
// +----------------------------------------------------------------------------+
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        hlt,
  input  logic [4:0]  phase,
  input  logic [31:0] pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic [31:0] ir,
  output logic        ir_valid,
  output logic        fetch_busy,
  output logic        fetch_fault,
  output logic [1:0]  fault_cause
);

  if_state_e   state_q,       state_d;
  logic        imem_req_q,    imem_req_d;
  logic [31:0] imem_addr_q,   imem_addr_d;
  logic [31:0] ir_q,          ir_d;
  logic        ir_valid_q,    ir_valid_d;
  logic        fetch_fault_q, fetch_fault_d;
  logic [1:0]  fault_cause_q, fault_cause_d;

  logic tmr_clr;
  logic tmr_expired;

  // Counter sits at zero outside REQ, so it starts from zero on entry.
  assign tmr_clr = hlt || (state_q != IF_REQ);

  fetch_timer #(
    .LIMIT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .n_rst   (n_rst),
    .clr     (tmr_clr),
    .en      (!imem_ack),
    .expired (tmr_expired)
  );

  always_comb begin
    state_d       = state_q;
    imem_req_d    = imem_req_q;
    imem_addr_d   = imem_addr_q;
    ir_d          = ir_q;
    ir_valid_d    = 1'b0;
    fetch_fault_d = fetch_fault_q;
    fault_cause_d = fault_cause_q;

    if (hlt) begin
      state_d       = IF_IDLE;
      imem_req_d    = 1'b0;
      imem_addr_d   = '0;
      ir_d          = '0;
      fetch_fault_d = 1'b0;
      fault_cause_d = IF_FLT_NONE;
    end else begin
      case (state_q)
        IF_IDLE: begin
          if (phase == PH_F) begin
            if (word_aligned(pc[1:0])) begin
              imem_addr_d = pc;
              imem_req_d  = 1'b1;
              state_d     = IF_REQ;
            end else begin
              fetch_fault_d = 1'b1;
              fault_cause_d = IF_FLT_ALIGN;
              state_d       = IF_FAULT;
            end
          end
        end
        IF_REQ: begin
          // Ack takes priority over an expiring timer in the same cycle.
          if (imem_ack) begin
            ir_d       = imem_rdata;
            ir_valid_d = 1'b1;
            imem_req_d = 1'b0;
            state_d    = IF_IDLE;
          end else if (tmr_expired) begin
            imem_req_d    = 1'b0;
            fetch_fault_d = 1'b1;
            fault_cause_d = IF_FLT_TMO;
            state_d       = IF_FAULT;
          end
        end
        IF_FAULT: begin
          state_d = IF_FAULT;
        end
        default: begin
          state_d = IF_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q       <= IF_IDLE;
      imem_req_q    <= 1'b0;
      imem_addr_q   <= '0;
      ir_q          <= '0;
      ir_valid_q    <= 1'b0;
      fetch_fault_q <= 1'b0;
      fault_cause_q <= IF_FLT_NONE;
    end else begin
      state_q       <= state_d;
      imem_req_q    <= imem_req_d;
      imem_addr_q   <= imem_addr_d;
      ir_q          <= ir_d;
      ir_valid_q    <= ir_valid_d;
      fetch_fault_q <= fetch_fault_d;
      fault_cause_q <= fault_cause_d;
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = imem_addr_q;
  assign ir          = ir_q;
  assign ir_valid    = ir_valid_q;
  assign fetch_busy  = (state_q == IF_REQ);
  assign fetch_fault = fetch_fault_q;
  assign fault_cause = fault_cause_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_instr_fetch: directed and randomized fetches against a cycle-indexed     |
// | outcome model.  Rev 1.0                                                     |
// +----------------------------------------------------------------------------+
module tb_instr_fetch;
  import instr_fetch_pkg::*;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        hlt;
  logic [4:0]  phase;
  logic [31:0] pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic [31:0] ir;
  logic        ir_valid;
  logic        fetch_busy;
  logic        fetch_fault;
  logic [1:0]  fault_cause;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] m_ir = '0;

  instr_fetch #(.TIMEOUT(T)) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .hlt         (hlt),
    .phase       (phase),
    .pc          (pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_ack    (imem_ack),
    .ir          (ir),
    .ir_valid    (ir_valid),
    .fetch_busy  (fetch_busy),
    .fetch_fault (fetch_fault),
    .fault_cause (fault_cause)
  );

  always #5 clk = ~clk;

  // {imem_req, fetch_busy, ir_valid, fetch_fault, fault_cause}
  wire [5:0] status = {imem_req, fetch_busy, ir_valid, fetch_fault, fault_cause};

  task automatic test_reset();
    n_rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_vec++; if (status !== 6'b0) begin n_err++; $display("FAIL reset_status got %b exp %b", status, 6'b0); end
    n_vec++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL reset_addr got %h exp 0", imem_addr); end
    n_vec++; if (ir !== 32'h0) begin n_err++; $display("FAIL reset_ir got %h exp 0", ir); end
    @(posedge clk); #1;
    n_rst = 1'b1;
    @(negedge clk);
    n_vec++; if (status !== 6'b0) begin n_err++; $display("FAIL post_reset_status got %b exp %b", status, 6'b0); end
    @(posedge clk); #1;
    m_ir = '0;
  endtask

  // ack_c: cycle (counted from the PH_F cycle) in which ack is driven; <=0 means never.
  task automatic run_fetch(input string name, input logic [31:0] a_pc, input int ack_c, input logic [31:0] rd);
    logic        aligned;
    int          done;
    logic        e_req, e_flt, e_val;
    logic [1:0]  e_cause;
    logic [31:0] e_ir;
    logic [5:0]  e_st;
    aligned = (a_pc[1:0] == 2'b00);
    done    = (aligned && ack_c >= 1 && ack_c <= T + 1) ? ack_c : 0;

    hlt = 1'b0; imem_ack = 1'b0; phase = PH_F; pc = a_pc; imem_rdata = $urandom;
    @(negedge clk);
    n_vec++; if (status !== 6'b0) begin n_err++; $display("FAIL %s c0_status got %b exp %b", name, status, 6'b0); end
    @(posedge clk); #1;

    for (int c = 1; c <= T + 3; c++) begin
      if (!aligned) begin
        e_req = 1'b0; e_flt = 1'b1; e_cause = 2'b01;
      end else if (done != 0) begin
        e_req = (c <= done); e_flt = 1'b0; e_cause = 2'b00;
      end else begin
        e_req = (c <= T + 1); e_flt = (c >= T + 2); e_cause = e_flt ? 2'b10 : 2'b00;
      end
      e_val = (done != 0) && (c == done + 1);
      e_ir  = (done != 0 && c > done) ? rd : m_ir;
      e_st  = {e_req, e_req, e_val, e_flt, e_cause};

      // A stray PH_F is only legal while the unit is busy or faulted.
      phase      = ((e_req || e_flt) && $urandom_range(0, 1) == 1) ? PH_F : PH_D;
      pc         = $urandom;
      imem_ack   = (c == ack_c);
      imem_rdata = (c == ack_c) ? rd : $urandom;

      @(negedge clk);
      n_vec++; if (status !== e_st) begin n_err++; $display("FAIL %s status c=%0d got %b exp %b", name, c, status, e_st); end
      n_vec++; if (ir !== e_ir) begin n_err++; $display("FAIL %s ir c=%0d got %h exp %h", name, c, ir, e_ir); end
      if (e_req) begin
        n_vec++; if (imem_addr !== a_pc) begin n_err++; $display("FAIL %s addr c=%0d got %h exp %h", name, c, imem_addr, a_pc); end
      end
      @(posedge clk); #1;
    end
    imem_ack = 1'b0; phase = PH_D;
    if (done != 0) m_ir = rd;

    if (!aligned || done == 0) begin
      hlt = 1'b1;
      @(posedge clk); #1;
      hlt = 1'b0; m_ir = '0;
      @(negedge clk);
      n_vec++; if (status !== 6'b0) begin n_err++; $display("FAIL %s hlt_status got %b exp %b", name, status, 6'b0); end
      n_vec++; if ({imem_addr, ir} !== 64'h0) begin n_err++; $display("FAIL %s hlt_regs got addr %h ir %h exp 0", name, imem_addr, ir); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_aligned();    run_fetch("aligned",    32'h0000_0100, 3,     32'hDEAD_BEEF); endtask
  task automatic test_fastest();    run_fetch("fastest",    32'h0000_0104, 1,     32'h1234_5678); endtask
  task automatic test_misaligned(); run_fetch("misaligned", 32'h0000_0102, 0,     32'hAAAA_5555); endtask
  task automatic test_timeout();    run_fetch("timeout",    32'h0000_0108, 0,     32'h0BAD_F00D); endtask
  task automatic test_tmo_race();   run_fetch("tmo_race",   32'h0000_010C, T + 1, 32'hCAFE_0001); endtask

  task automatic test_hlt_mid();
    hlt = 1'b0; imem_ack = 1'b0; phase = PH_F; pc = 32'h0000_0200;
    @(posedge clk); #1;
    phase = PH_D;
    @(negedge clk);
    n_vec++; if (status !== 6'b110000) begin n_err++; $display("FAIL hlt_mid c1 got %b exp %b", status, 6'b110000); end
    @(posedge clk); #1;
    hlt = 1'b1;
    @(posedge clk); #1;
    hlt = 1'b0;
    @(negedge clk);
    n_vec++; if (status !== 6'b0) begin n_err++; $display("FAIL hlt_mid c3 got %b exp %b", status, 6'b0); end
    n_vec++; if ({imem_addr, ir} !== 64'h0) begin n_err++; $display("FAIL hlt_mid c3_regs got addr %h ir %h exp 0", imem_addr, ir); end
    @(posedge clk); #1;
    imem_ack = 1'b1; imem_rdata = 32'h5A5A_A5A5;
    @(posedge clk); #1;
    imem_ack = 1'b0;
    @(negedge clk);
    n_vec++; if (ir !== 32'h0) begin n_err++; $display("FAIL hlt_mid late_ack_ir got %h exp 0", ir); end
    n_vec++; if (status !== 6'b0) begin n_err++; $display("FAIL hlt_mid late_ack_status got %b exp %b", status, 6'b0); end
    @(posedge clk); #1;
    m_ir = '0;
  endtask

  task automatic test_async_reset();
    hlt = 1'b0; imem_ack = 1'b0; phase = PH_F; pc = 32'h0000_0300;
    @(posedge clk); #1;
    phase = PH_D;
    @(negedge clk);
    n_vec++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL arst pre_req got %b exp 1", imem_req); end
    #1 n_rst = 1'b0;
    #1;
    n_vec++; if (status !== 6'b0) begin n_err++; $display("FAIL arst immediate_status got %b exp %b", status, 6'b0); end
    n_vec++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL arst immediate_addr got %h exp 0", imem_addr); end
    @(posedge clk); #1;
    n_rst = 1'b1; m_ir = '0;
    run_fetch("after_arst", 32'h0000_0304, 2, 32'hFEED_FACE);
  endtask

  task automatic test_random();
    logic [31:0] a_pc;
    for (int i = 0; i < 16; i++) begin
      a_pc = $urandom;
      if ($urandom_range(0, 4) != 0) a_pc[1:0] = 2'b00;
      run_fetch("random", a_pc, int'($urandom_range(0, T + 3)), $urandom);
      // Ack with nothing outstanding must not touch the IR.
      phase = PH_D; imem_ack = 1'b1; imem_rdata = $urandom;
      @(posedge clk); #1;
      imem_ack = 1'b0;
      @(negedge clk);
      n_vec++; if (ir !== m_ir) begin n_err++; $display("FAIL stray_ack ir got %h exp %h", ir, m_ir); end
      n_vec++; if (status !== 6'b0) begin n_err++; $display("FAIL stray_ack status got %b exp %b", status, 6'b0); end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    n_rst = 1'b0; hlt = 1'b0; phase = PH_D; pc = '0; imem_ack = 1'b0; imem_rdata = '0;
    test_reset();
    test_aligned();
    test_fastest();
    test_misaligned();
    test_hlt_mid();
    test_timeout();
    test_tmo_race();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
